aes_core_sequencer: RTL and testbench

//  Control FSM between the SPI front end and the AES datapath (KeyExpansion + Cipher).

---
 rtl/aes_core_sequencer_if.sv | 28 ++
 rtl/aes_core_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_aes_core_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_core_sequencer_if.sv
// Block handshake bundle between the SPI front end and the AES sequencer:
// plaintext in over blk_valid/blk_ready, ciphertext out over ct_valid/ct_ready.
interface aes_core_sequencer_if;
  logic [127:0] blk_in;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] ct_out;
  logic         ct_valid;
  logic         ct_ready;

  modport master (
    output blk_in,
    output blk_valid,
    output ct_ready,
    input  blk_ready,
    input  ct_out,
    input  ct_valid
  );

  modport slave (
    input  blk_in,
    input  blk_valid,
    input  ct_ready,
    output blk_ready,
    output ct_out,
    output ct_valid
  );
endinterface

// File: rtl/aes_core_sequencer.sv
// Control FSM between the SPI front end and the AES datapath. Latches a key,
// lets KeyExpansion settle, then runs one plaintext block at a time through
// Cipher using its cs/flag protocol, with a watchdog for a hung core.
module aes_core_sequencer #(
  parameter int KEY_SETTLE = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   key_size_i,
  input  logic [255:0] key_in_i,
  input  logic         key_load_i,
  output logic         key_ack_o,
  output logic         key_err_o,
  output logic         key_valid_o,
  output logic         timeout_err_o,
  output logic [3:0]   core_Nk_o,
  output logic [3:0]   core_Nr_o,
  output logic [255:0] core_key_o,
  output logic         core_cs_o,
  output logic [127:0] core_init_o,
  input  logic [127:0] core_out_i,
  input  logic         core_flag_i,
  aes_core_sequencer_if.slave bus
);

  localparam int CW = (KEY_SETTLE > 1) ? $clog2(KEY_SETTLE) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] SETTLE_INIT = CW'(KEY_SETTLE - 1);
  localparam logic [TW-1:0] TCNT_LAST   = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_NOKEY  = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_READY  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [1:0]    size_q, size_d;
  logic [255:0]  key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          key_ack_q, key_ack_d;
  logic          key_err_q, key_err_d;
  logic          key_valid_q, key_valid_d;
  logic          timeout_q, timeout_d;
  logic          cs_q, cs_d;
  logic [127:0]  init_q, init_d;
  logic [127:0]  ct_q, ct_d;
  logic          ct_valid_q, ct_valid_d;
  logic          key_accept;
  logic          blk_ready;

  // Next-state logic: key loads take priority over everything else in NOKEY/READY.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    key_ack_d   = 1'b0;
    key_err_d   = 1'b0;
    key_valid_d = key_valid_q;
    timeout_d   = 1'b0;
    cs_d        = cs_q;
    init_d      = init_q;
    ct_d        = ct_q;
    ct_valid_d  = ct_valid_q;

    key_accept = key_load_i && (key_size_i != 2'b11) &&
                 ((state_q == S_NOKEY) || (state_q == S_READY));
    blk_ready  = (state_q == S_READY) && !key_load_i;

    if (key_load_i && !key_accept) begin
      key_err_d = 1'b1;
    end

    if (key_accept) begin
      size_d      = key_size_i;
      case (key_size_i)
        2'b00:   key_d = {key_in_i[255:128], 128'b0};
        2'b01:   key_d = {key_in_i[255:64], 64'b0};
        default: key_d = key_in_i;
      endcase
      key_ack_d   = 1'b1;
      key_valid_d = 1'b0;
      cnt_d       = SETTLE_INIT;
      state_d     = S_SETTLE;
    end else begin
      case (state_q)
        S_NOKEY: ;
        S_SETTLE: begin
          if (cnt_q == '0) begin
            key_valid_d = 1'b1;
            state_d     = S_READY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_READY: begin
          if (bus.blk_valid && blk_ready) begin
            init_d  = bus.blk_in;
            cs_d    = 1'b1;
            tcnt_d  = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (core_flag_i && (tcnt_q != '0)) begin
            ct_d       = core_out_i;
            ct_valid_d = 1'b1;
            state_d    = S_HOLD;
          end else if (tcnt_q == TCNT_LAST) begin
            timeout_d = 1'b1;
            cs_d      = 1'b0;
            state_d   = S_GAP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.ct_ready) begin
            ct_valid_d = 1'b0;
            cs_d       = 1'b0;
            state_d    = S_GAP;
          end
        end
        S_GAP:   state_d = S_READY;
        default: state_d = S_NOKEY;
      endcase
    end
  end

  // State and output registers; reset drops any block in flight and the key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_NOKEY;
      size_q      <= 2'b00;
      key_q       <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      key_ack_q   <= 1'b0;
      key_err_q   <= 1'b0;
      key_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      cs_q        <= 1'b0;
      init_q      <= '0;
      ct_q        <= '0;
      ct_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      key_ack_q   <= key_ack_d;
      key_err_q   <= key_err_d;
      key_valid_q <= key_valid_d;
      timeout_q   <= timeout_d;
      cs_q        <= cs_d;
      init_q      <= init_d;
      ct_q        <= ct_d;
      ct_valid_q  <= ct_valid_d;
    end
  end

  // Round parameters follow directly from the latched key size.
  always_comb begin
    case (size_q)
      2'b00:   begin core_Nk_o = 4'd4; core_Nr_o = 4'd10; end
      2'b01:   begin core_Nk_o = 4'd6; core_Nr_o = 4'd12; end
      default: begin core_Nk_o = 4'd8; core_Nr_o = 4'd14; end
    endcase
  end

  assign key_ack_o     = key_ack_q;
  assign key_err_o     = key_err_q;
  assign key_valid_o   = key_valid_q;
  assign timeout_err_o = timeout_q;
  assign core_key_o    = key_q;
  assign core_cs_o     = cs_q;
  assign core_init_o   = init_q;
  assign bus.blk_ready = blk_ready;
  assign bus.ct_out    = ct_q;
  assign bus.ct_valid  = ct_valid_q;

endmodule

// File: tb/tb_aes_core_sequencer.sv
// Bench for aes_core_sequencer: a behavioural Cipher stand-in answers cs with
// flag after a programmable latency, and a queue of expected ciphertexts is
// built from the key/plaintext the bench offers.
module tb_aes_core_sequencer;
  localparam int KEY_SETTLE = 4;
  localparam int TIMEOUT    = 64;

  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   keySize;
  logic [255:0] keyIn;
  logic         keyLoad;
  logic         keyAck, keyErr, keyValid, timeoutErr;
  logic [3:0]   coreNk, coreNr;
  logic [255:0] coreKey;
  logic         coreCs;
  logic [127:0] coreInit;
  logic [127:0] coreOut;
  logic         coreFlag;

  aes_core_sequencer_if busIf();

  aes_core_sequencer #(.KEY_SETTLE(KEY_SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_size_i   (keySize),
    .key_in_i     (keyIn),
    .key_load_i   (keyLoad),
    .key_ack_o    (keyAck),
    .key_err_o    (keyErr),
    .key_valid_o  (keyValid),
    .timeout_err_o(timeoutErr),
    .core_Nk_o    (coreNk),
    .core_Nr_o    (coreNr),
    .core_key_o   (coreKey),
    .core_cs_o    (coreCs),
    .core_init_o  (coreInit),
    .core_out_i   (coreOut),
    .core_flag_i  (coreFlag),
    .bus          (busIf)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCount = 0;
  int cipherLat = 5;
  bit forceFlagZero = 1'b0;
  int readyMode = 0;
  logic [255:0] keyModel = '0;
  int nkModel = 4;
  logic [127:0] expQ[$];

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in for Cipher: real FIPS-197 answers for the reference vectors,
  // a keyed mixing function for everything else.
  function automatic logic [127:0] fakeCipher(input logic [127:0] pt, input logic [255:0] key,
                                              input logic [3:0] nk);
    if (pt == PT && nk == 4'd4 && key == {K128, 128'h0}) return CT128;
    if (pt == PT && nk == 4'd6 && key == {K192, 64'h0})  return CT192;
    if (pt == PT && nk == 4'd8 && key == K256)           return CT256;
    return pt ^ key[255:128] ^ key[127:0] ^ {32{nk}};
  endfunction

  function automatic logic [255:0] randKey();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    logic [127:0] r = '0;
    for (int i = 0; i < 4; i++) r = {r[95:0], 32'($urandom)};
    return r;
  endfunction

  // Cipher behaviour: flag rises cipherLat cycles after cs goes high, cs low restarts it.
  initial begin
    int coreCnt = 0;
    coreFlag = 1'b0;
    coreOut  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!coreCs || forceFlagZero) begin
        coreCnt  = 0;
        coreFlag = 1'b0;
      end else begin
        coreCnt++;
        if (coreCnt >= cipherLat && !coreFlag) begin
          coreFlag = 1'b1;
          coreOut  = fakeCipher(coreInit, coreKey, coreNk);
        end
      end
    end
  end

  // Ciphertext consumer: drives ct_ready, checks held data and every delivered block.
  initial begin
    logic [127:0] prevCt = '0;
    bit prevHold = 1'b0;
    busIf.ct_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevHold = 1'b0;
        continue;
      end
      case (readyMode)
        0:       busIf.ct_ready = 1'b1;
        1:       busIf.ct_ready = 1'($urandom_range(0, 1));
        default: busIf.ct_ready = 1'b0;
      endcase
      if (busIf.ct_valid && prevHold) checkOutput("ct_stable", busIf.ct_out, prevCt);
      if (busIf.ct_valid && busIf.ct_ready) begin
        if (expQ.size() == 0) checkOutput("ct_pending_count", expQ.size(), 1);
        else                  checkOutput("ct", busIf.ct_out, expQ.pop_front());
      end
      prevHold = busIf.ct_valid && !busIf.ct_ready;
      prevCt   = busIf.ct_out;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_key_valid"}, keyValid, 0);
    checkOutput({tag, "_key_ack"}, keyAck, 0);
    checkOutput({tag, "_blk_ready"}, busIf.blk_ready, 0);
    checkOutput({tag, "_ct_valid"}, busIf.ct_valid, 0);
    checkOutput({tag, "_core_cs"}, coreCs, 0);
    checkOutput({tag, "_core_Nk"}, coreNk, 4);
    checkOutput({tag, "_core_Nr"}, coreNr, 10);
    checkOutput({tag, "_core_key"}, coreKey, 0);
    checkOutput({tag, "_timeout"}, timeoutErr, 0);
  endtask

  // Key load request; on acceptance the expected padded key and round counts are derived.
  task automatic loadKey(input logic [1:0] sz, input logic [255:0] k, input bit expectAccept,
                         input bit withBlock);
    int len;
    int n;
    logic [255:0] ones;
    keySize = sz;
    keyIn   = k;
    keyLoad = 1'b1;
    if (withBlock) begin
      busIf.blk_in    = rand128();
      busIf.blk_valid = 1'b1;
      #1;
      checkOutput("blk_ready_vs_keyload", busIf.blk_ready, 0);
    end
    @(negedge clk);
    keyLoad = 1'b0;
    busIf.blk_valid = 1'b0;
    if (!expectAccept) begin
      checkOutput("key_err", keyErr, 1);
      checkOutput("key_ack_on_reject", keyAck, 0);
      return;
    end
    checkOutput("key_ack", keyAck, 1);
    checkOutput("key_err_on_accept", keyErr, 0);
    checkOutput("key_valid_cleared", keyValid, 0);
    if (withBlock) checkOutput("no_run_on_keyload", coreCs, 0);
    len      = (sz == 2'b00) ? 128 : (sz == 2'b01) ? 192 : 256;
    ones     = '1;
    keyModel = k & (ones << (256 - len));
    nkModel  = len / 32;
    n = 0;
    while (!keyValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("key_settle_cycles", n, KEY_SETTLE);
    checkOutput("core_key", coreKey, keyModel);
    checkOutput("core_Nk", coreNk, nkModel);
    checkOutput("core_Nr", coreNr, nkModel + 6);
  endtask

  // Offer one plaintext block and wait for the handshake; returns the handshake cycle.
  task automatic applyStimulus(input logic [127:0] pt, input bit expectCt, output int hsCycle);
    int n = 0;
    hsCycle = 0;
    busIf.blk_in    = pt;
    busIf.blk_valid = 1'b1;
    while (!busIf.blk_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checkOutput("blk_accept_wait", n, 0);
      busIf.blk_valid = 1'b0;
      return;
    end
    hsCycle = cycleCount + 1;
    if (expectCt) expQ.push_back(fakeCipher(pt, keyModel, 4'(nkModel)));
    @(negedge clk);
    busIf.blk_valid = 1'b0;
    checkOutput("core_init", coreInit, pt);
    checkOutput("core_cs_after_hs", coreCs, 1);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((expQ.size() != 0 || !busIf.blk_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) checkOutput("idle_wait", n, 0);
  endtask

  initial begin
    int h0, h1, h2, n, early;
    keySize = 2'b00;
    keyIn   = '0;
    keyLoad = 1'b0;
    busIf.blk_in    = '0;
    busIf.blk_valid = 1'b0;

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Reserved size in NOKEY: rejected, key stays invalid.
    loadKey(2'b11, randKey(), 1'b0, 1'b0);
    checkOutput("key_valid_after_reserved_nokey", keyValid, 0);

    // AES-128 reference vector, with junk below the key length.
    loadKey(2'b00, {K128, rand128()}, 1'b1, 1'b0);
    cipherLat = 6;
    applyStimulus(PT, 1'b1, h0);
    waitIdle();

    // Reserved size in READY: rejected, existing key untouched.
    loadKey(2'b11, randKey(), 1'b0, 1'b0);
    checkOutput("key_valid_after_reserved_ready", keyValid, 1);
    checkOutput("core_Nk_after_reserved", coreNk, 4);

    // AES-192 reference vector.
    loadKey(2'b01, {K192, 64'(rand128())}, 1'b1, 1'b0);
    applyStimulus(PT, 1'b1, h0);
    waitIdle();

    // AES-256: three back-to-back blocks, one per Cipher latency plus 3.
    loadKey(2'b10, K256, 1'b1, 1'b0);
    cipherLat = 8;
    applyStimulus(PT, 1'b1, h0);
    applyStimulus(rand128(), 1'b1, h1);
    applyStimulus(rand128(), 1'b1, h2);
    checkOutput("throughput_1", h1 - h0, cipherLat + 3);
    checkOutput("throughput_2", h2 - h1, cipherLat + 3);
    waitIdle();

    // Consumer stalls: ciphertext held, no second block accepted.
    cipherLat = 5;
    readyMode = 2;
    applyStimulus(rand128(), 1'b1, h0);
    n = 0;
    while (!busIf.ct_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("hold_ct_valid", busIf.ct_valid, 1);
    busIf.blk_in    = rand128();
    busIf.blk_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checkOutput("hold_blk_ready", busIf.blk_ready, 0);
    end
    busIf.blk_valid = 1'b0;
    readyMode = 0;
    waitIdle();

    // Key load while a block is running: rejected, block completes with old key.
    cipherLat = 10;
    applyStimulus(rand128(), 1'b1, h0);
    loadKey(2'b00, randKey(), 1'b0, 1'b0);
    waitIdle();
    checkOutput("core_Nk_after_run_reject", coreNk, 8);

    // Key load and block offered together in READY: key wins.
    loadKey(2'b00, randKey(), 1'b1, 1'b1);
    cipherLat = 4;
    applyStimulus(rand128(), 1'b1, h0);
    waitIdle();

    // Hung core: timeout after TIMEOUT RUN cycles, no ciphertext.
    forceFlagZero = 1'b1;
    applyStimulus(rand128(), 1'b0, h0);
    early = 0;
    repeat (TIMEOUT - 1) begin
      @(negedge clk);
      early += int'(timeoutErr) + int'(busIf.ct_valid);
    end
    checkOutput("timeout_not_early", early, 0);
    @(negedge clk);
    checkOutput("timeout_err", timeoutErr, 1);
    checkOutput("timeout_cs_low", coreCs, 0);
    checkOutput("timeout_no_ct", busIf.ct_valid, 0);
    @(negedge clk);
    checkOutput("timeout_pulse_width", timeoutErr, 0);
    forceFlagZero = 1'b0;
    waitIdle();

    // Randomized traffic: random keys, latencies, plaintexts and consumer stalls.
    readyMode = 1;
    for (int i = 0; i < 30; i++) begin
      if (i % 8 == 0) loadKey(2'($urandom_range(0, 2)), randKey(), 1'b1, 1'b0);
      cipherLat = $urandom_range(2, 20);
      applyStimulus(rand128(), 1'b1, h0);
      waitIdle();
    end

    // Asynchronous reset in the middle of a block.
    readyMode = 0;
    cipherLat = 30;
    applyStimulus(rand128(), 1'b0, h0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_blk_ready", busIf.blk_ready, 0);
    checkOutput("post_reset_key_valid", keyValid, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
